// File: rtl/input_dev_mmio.sv
// Multi-channel debounced input device with sticky change flags, maskable
// interrupt and a registered word-addressed CPU register port.

module input_dev_chan #(
  parameter int WIDTH           = 32,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] stable,
  output logic             accept
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [WIDTH-1:0] s1_q, s1_d, s2_q, s2_d;
  logic [WIDTH-1:0] cand_q, cand_d, stable_q, stable_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  always_comb begin
    s1_d     = din;
    s2_d     = s1_q;
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    stable_d = stable_q;
    accept   = 1'b0;
    // Any movement of the synchronised value restarts the stability window.
    if (s2_q != cand_q) begin
      cand_d = s2_q;
      cnt_d  = '0;
    end else if (cnt_q < CW'(DEBOUNCE_CYCLES)) begin
      cnt_d = cnt_q + 1'b1;
    end else if (cand_q != stable_q) begin
      stable_d = cand_q;
      accept   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q     <= '0;
      s2_q     <= '0;
      cand_q   <= '0;
      cnt_q    <= '0;
      stable_q <= '0;
    end else begin
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      cand_q   <= cand_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign stable = stable_q;
endmodule

module input_dev_mmio #(
  parameter int WIDTH           = 32,
  parameter int CHANNELS        = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int ADDR_W          = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] DataIn,
  input  logic [ADDR_W-1:0]         Addr,
  input  logic                      Rd,
  input  logic                      Wr,
  input  logic [WIDTH-1:0]          WrData,
  output logic [WIDTH-1:0]          DataOut,
  output logic                      RdValid,
  output logic                      Irq
);
  localparam logic [ADDR_W-1:0] STAT_A = ADDR_W'(CHANNELS);
  localparam logic [ADDR_W-1:0] MASK_A = ADDR_W'(CHANNELS + 1);

  logic [CHANNELS-1:0][WIDTH-1:0] stable;
  logic [CHANNELS-1:0]            acc;

  logic [CHANNELS-1:0] chg_q, chg_d, mask_q, mask_d, rd_clr;
  logic [WIDTH-1:0]    dout_q, dout_d, rd_val;
  logic                rdvalid_q, rdvalid_d, irq_q, irq_d;

  for (genvar k = 0; k < CHANNELS; k++) begin : g_chan
    input_dev_chan #(
      .WIDTH           (WIDTH),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_chan (
      .clk    (clk),
      .rst    (rst),
      .din    (DataIn[k*WIDTH +: WIDTH]),
      .stable (stable[k]),
      .accept (acc[k])
    );
  end

  always_comb begin
    rd_val = '0;
    for (int k = 0; k < CHANNELS; k++)
      if (Addr == ADDR_W'(k)) rd_val = stable[k];
    if (Addr == STAT_A) rd_val = WIDTH'(chg_q);
    if (Addr == MASK_A) rd_val = WIDTH'(mask_q);

    // Clear only what the CPU actually saw; a flag set on this edge survives.
    rd_clr    = (Rd && Addr == STAT_A) ? chg_q : '0;
    chg_d     = (chg_q & ~rd_clr) | acc;
    mask_d    = (Wr && Addr == MASK_A) ? WrData[CHANNELS-1:0] : mask_q;
    dout_d    = Rd ? rd_val : dout_q;
    rdvalid_d = Rd;
    irq_d     = |(chg_d & mask_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      chg_q     <= '0;
      mask_q    <= '0;
      dout_q    <= '0;
      rdvalid_q <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      chg_q     <= chg_d;
      mask_q    <= mask_d;
      dout_q    <= dout_d;
      rdvalid_q <= rdvalid_d;
      irq_q     <= irq_d;
    end
  end

  assign DataOut = dout_q;
  assign RdValid = rdvalid_q;
  assign Irq     = irq_q;
endmodule

// File: tb/tb_input_dev_mmio.sv
// Scoreboard bench for input_dev_mmio: directed scenarios followed by random
// traffic, checked against a sample-history reference model.

module tb_input_dev_mmio;
  localparam int W  = 8;
  localparam int CH = 2;
  localparam int D  = 4;
  localparam int AW = 4;
  localparam int HN = D + 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [CH*W-1:0] DataIn;
  logic [AW-1:0]   Addr;
  logic            Rd, Wr;
  logic [W-1:0]    WrData;
  logic [W-1:0]    DataOut;
  logic            RdValid, Irq;

  input_dev_mmio #(.WIDTH(W), .CHANNELS(CH), .DEBOUNCE_CYCLES(D), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .DataIn(DataIn), .Addr(Addr), .Rd(Rd), .Wr(Wr),
    .WrData(WrData), .DataOut(DataOut), .RdValid(RdValid), .Irq(Irq)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int nchk = 0;

  // Reference model state
  logic            m_ok = 1'b0;
  logic [CH*W-1:0] dly0, dly1, x;
  logic [W-1:0]    m_stable [CH];
  logic [W-1:0]    hist [CH][HN];
  int              hcnt [CH];
  logic [CH-1:0]   m_chg, m_mask, clr, setb;
  logic            m_irq, m_rdvalid, eq;
  logic [W-1:0]    m_dout, rv, xv;
  int              ai;
  logic [W-1:0]    exp_q [$];

  // A channel's stable value moves to v once the last D+2 synchronised samples
  // (the input seen two edges earlier) all equal v; reset counts as a 0 sample.
  always @(posedge clk) begin
    if (rst) begin
      m_ok = 1'b1; dly0 = '0; dly1 = '0;
      m_chg = '0; m_mask = '0; m_irq = 1'b0; m_rdvalid = 1'b0; m_dout = '0;
      exp_q.delete();
      for (int k = 0; k < CH; k++) begin
        m_stable[k] = '0; hist[k][HN-1] = '0; hcnt[k] = 1;
      end
    end else begin
      ai  = int'(Addr);
      clr = '0;
      if (Rd) begin
        rv = '0;
        if (ai < CH) rv = m_stable[ai];
        else if (ai == CH) begin rv = W'(m_chg); clr = m_chg; end
        else if (ai == CH + 1) rv = W'(m_mask);
        exp_q.push_back(rv);
        m_dout = rv;
      end
      m_rdvalid = Rd;
      x = dly1; dly1 = dly0; dly0 = DataIn;
      setb = '0;
      for (int k = 0; k < CH; k++) begin
        xv = x[k*W +: W];
        for (int i = 0; i < HN - 1; i++) hist[k][i] = hist[k][i+1];
        hist[k][HN-1] = xv;
        if (hcnt[k] < HN) hcnt[k]++;
        eq = (hcnt[k] == HN);
        for (int i = 0; i < HN; i++) if (hist[k][i] != xv) eq = 1'b0;
        if (eq && xv != m_stable[k]) begin m_stable[k] = xv; setb[k] = 1'b1; end
      end
      m_chg = (m_chg & ~clr) | setb;
      if (Wr && ai == CH + 1) m_mask = WrData[CH-1:0];
      m_irq = |(m_chg & m_mask);
    end
  end

  // Monitor: pops an expected word whenever the DUT presents read data.
  logic [W-1:0] e;
  always @(negedge clk) begin
    if (m_ok) begin
      nchk++;
      if (RdValid !== m_rdvalid) begin
        errs++; $display("FAIL rdvalid t=%0t got=%b exp=%b", $time, RdValid, m_rdvalid);
      end
      nchk++;
      if (Irq !== m_irq) begin
        errs++; $display("FAIL irq t=%0t got=%b exp=%b", $time, Irq, m_irq);
      end
      nchk++;
      if (RdValid) begin
        if (exp_q.size() == 0) begin
          errs++; $display("FAIL rd_unexpected t=%0t got=%h exp=none", $time, DataOut);
        end else begin
          e = exp_q.pop_front();
          if (DataOut !== e) begin
            errs++; $display("FAIL rddata t=%0t got=%h exp=%h", $time, DataOut, e);
          end
        end
      end else if (DataOut !== m_dout) begin
        errs++; $display("FAIL dout_hold t=%0t got=%h exp=%h", $time, DataOut, m_dout);
      end
    end
  end

  task automatic cyc(input logic rd, input int a, input logic wr, input int wd);
    Rd = rd; Addr = AW'(a); Wr = wr; WrData = W'(wd);
    @(posedge clk); #1;
    Rd = 1'b0; Wr = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 0, 1'b0, 0);
  endtask

  task automatic set_ch(input int k, input logic [W-1:0] v);
    DataIn[k*W +: W] = v;
  endtask

  int hold [CH];
  int a;

  initial begin
    rst = 1'b1; DataIn = '0; Addr = '0; Rd = 1'b0; Wr = 1'b0; WrData = '0;
    @(posedge clk); #1;
    idle(1);
    rst = 1'b0;
    idle(2);

    // Latency: read channel 0 every cycle across the acceptance edge
    set_ch(0, 8'h5A);
    repeat (12) cyc(1'b1, 0, 1'b0, 0);
    cyc(1'b1, 2, 1'b0, 0);

    // Glitch rejection then acceptance on channel 1
    set_ch(1, 8'hFF); idle(D);
    set_ch(1, 8'h00); idle(10);
    cyc(1'b1, 1, 1'b0, 0); cyc(1'b1, 2, 1'b0, 0);
    set_ch(1, 8'hFF); idle(D + 2);
    set_ch(1, 8'h00); idle(10);
    cyc(1'b1, 1, 1'b0, 0); cyc(1'b1, 2, 1'b0, 0);

    // Masked interrupt
    set_ch(0, 8'h3C); idle(12);
    cyc(1'b1, 2, 1'b0, 0);
    set_ch(0, 8'h5A); idle(12);
    cyc(1'b0, 0, 1'b1, 8'h01); idle(2);
    cyc(1'b1, 2, 1'b0, 0); idle(2);

    // Set/clear collision: status read every cycle across an acceptance
    set_ch(1, 8'hFF);
    repeat (12) cyc(1'b1, 2, 1'b0, 0);

    // Out-of-range read, ignored write, simultaneous read+write of mask
    cyc(1'b1, 7, 1'b0, 0);
    cyc(1'b0, 0, 1'b1, 8'h33);
    cyc(1'b1, 0, 1'b0, 0);
    cyc(1'b1, 3, 1'b1, 8'h02);
    cyc(1'b1, 3, 1'b0, 0);
    cyc(1'b1, 9, 1'b1, 8'hFF);
    cyc(1'b1, 3, 1'b0, 0);

    // Reset mid-debounce
    set_ch(0, 8'h11); idle(4);
    rst = 1'b1; idle(1); rst = 1'b0;
    repeat (D + 8) cyc(1'b1, 0, 1'b0, 0);
    cyc(1'b1, 2, 1'b0, 0);

    // Random traffic with random hold lengths around the debounce window
    for (int k = 0; k < CH; k++) hold[k] = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < CH; k++) begin
        if (hold[k] == 0) begin
          set_ch(k, W'($urandom_range(0, 3) * 8'h55));
          hold[k] = $urandom_range(1, 10);
        end
        hold[k]--;
      end
      rst = ($urandom_range(0, 599) == 0);
      a = ($urandom_range(0, 3) == 0) ? CH : $urandom_range(0, 7);
      cyc(1'(($urandom_range(0, 1))), a, 1'(($urandom_range(0, 7) == 0)), int'($urandom));
      rst = 1'b0;
    end
    idle(3);

    nchk++;
    if (exp_q.size() != 0) begin
      errs++; $display("FAIL drain got=%0d pending exp=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end
endmodule
